foreground_extractor: RTL and testbench
=======================================

# foreground_extractor

- Pixel-rate background-subtraction stage that turns the incoming RGB video stream into the 1-bit `foregnd_px` consumed by the blob analyzer.
- Keeps a 2×2-subsampled 8-bit luma background model (320×240) in internal block RAM.
- Compares each pixel's luma against the model and updates the model with a running average.
- Sits between the camera/video timing front end and the blob analyzer, on `app_clk`.

## Interface

Parameters:
- `THRESH`, 24: foreground when |Y − bg| > THRESH (8-bit).
- `ALPHA_SHIFT`, 3: running-average learning rate 2^-ALPHA_SHIFT.
- `LEARN_FRAMES`, 4: frames of direct copy after reset/relearn (1–15).

Ports (one clock, `app_clk`; reset is asynchronous and active-low, `app_rst_n`):
- `app_clk`  in  1  pixel/app clock (same as vid_clk).
- `app_rst_n`  in  1  asynchronous active-low reset.
- `vid_hpos`  in  11  horizontal position of `vid_pix_in`.
- `vid_vpos`  in  11  vertical position of `vid_pix_in`.
- `vid_active_pix`  in  1  pixel valid.
- `vid_pix_in`  in  24  {R,G,B}, 8 bits each.
- `learn_req`  in  1  pulse: relearn background from next frame start.
- `bg_freeze`  in  1  level: suppress all model write-back.
- `foregnd_px`  out  1  foreground decision, 3 cycles after input.
- `fg_hpos`  out  11  `vid_hpos` delayed 3 cycles.
- `fg_vpos`  out  11  `vid_vpos` delayed 3 cycles.
- `bg_ready`  out  1  high in RUN state.

## Operation

- In-image pixel: `vid_active_pix` && hpos < 640 && vpos < 480. Other pixels give `foregnd_px`=0 and no write.
- Luma: Y = (77·R + 150·G + 29·B) >> 8, 16-bit intermediate, result 8 bits (max 255).
- Model address: (vpos>>1)·320 + (hpos>>1), 17 bits.
- Read every in-image pixel. Write only on cell owners (hpos[0]==0 && vpos[0]==0).
- d = Y − bg, 9-bit signed. fg = |d| > THRESH.
- LEARN state: write bg ← Y; `foregnd_px` forced 0.
- RUN state, fg==0: delta = d >>> ALPHA_SHIFT. If delta==0 and d≠0, delta = sign(d). bg ← bg + delta.
- RUN state, fg==1: bg ← bg + sign(d), a one-LSB creep that dissolves ghosts.
- Update always moves toward Y, so the result stays in 0..255 without clamping.
- `bg_freeze`=1 blocks all writes, including in LEARN; the frame counter still advances.
- State machine:
  - LEARN→RUN at frame end (hpos==639 && vpos==479 && active) when frame_cnt == LEARN_FRAMES−1.
  - Otherwise frame_cnt increments at each frame end.
  - Any state→LEARN, with frame_cnt←0, at the first frame start (hpos==0 && vpos==0 && active) after `learn_req`. The request is held in a pending flag until then.
  - `learn_req` arriving in the same cycle as a frame start takes effect at the next frame start. It is never dropped.
  - `learn_req` arriving in the same cycle as the final LEARN frame end: the RUN transition happens, then LEARN is re-entered at the next frame start.

## Timing

- Stage 0: latch Y-inputs; issue RAM read.
- Stage 1: Y and bg available.
- Stage 2: compare; compute update; RAM write.
- Stage 3: `foregnd_px`, `fg_hpos`, `fg_vpos` registered.
- Latency: exactly 3 cycles for all three outputs, fully pipelined at 1 pixel/cycle, no stalls.
- Read/write hazard: none. A cell is re-read no earlier than one line after its write.
- Reset values: `foregnd_px`=0, `fg_hpos`=0, `fg_vpos`=0, `bg_ready`=0, state=LEARN, frame_cnt=0, pending=0, pipeline valids=0.
- RAM contents are not reset; they are undefined until the first learned frame.
- Reset mid-frame: learning starts immediately on the remaining pixels. The partial frame counts at its frame end only if that frame end is seen.

## Structure

- Shared package/header:
  - H_IMG_RES=640, V_IMG_RES=480.
  - Model dimensions 320×240.
  - Luma coefficients 77/150/29.
  - State encodings ST_LEARN/ST_RUN.
- Sub-module `bg_model_ram`:
  - Simple dual-port 76800×8, one write port, one registered read port, same clock.
  - Inferred block RAM, no reset.

## Test plan

- Reset, then 4 uniform frames of RGB(100,100,100) (Y=100): `foregnd_px`=0 throughout; `bg_ready` rises 1 cycle after the 4th frame end.
- RUN with bg=100, 8×8 patch RGB(200,200,200) at (320,240): `foregnd_px`=1 on exactly those 64 pixels, 3 cycles later, with `fg_hpos`/`fg_vpos` matching. Those cells move 100→101 per frame.
- RUN with bg=100, full frame Y=110 (d=10 < THRESH): owner cells update by +1 (10>>>3=1); after 1 frame model reads 101, `foregnd_px`=0.
- RUN with bg=100, d=−3: delta floors to −1, model 99; d=+3 gives delta 0 forced to +1, model 101.
- `learn_req` pulsed mid-frame: `bg_ready` drops at the next frame start. After 4 frames of Y=50, `bg_ready`=1 and the model reads 50.
- `bg_freeze`=1 with Y=200 over bg=100 for 3 frames: `foregnd_px`=1, model stays 100. Assert `app_rst_n`=0 mid-line: all outputs 0 asynchronously.

Source files
------------

// File: rtl/foreground_extractor_pkg.sv
// Shared constants, state encoding and helpers for the background-subtraction stage.
// Luma and model addressing live here so every stage computes them identically.
package foreground_extractor_pkg;

  localparam int H_IMG_RES = 640;
  localparam int V_IMG_RES = 480;
  localparam int BG_W      = 320;
  localparam int BG_H      = 240;
  localparam int BG_DEPTH  = BG_W * BG_H;
  localparam int BG_AW     = 17;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef enum logic {
    ST_LEARN = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Coefficients sum to 256, so the 16-bit accumulator never overflows.
  function automatic logic [7:0] luma(input logic [23:0] rgb);
    logic [15:0] acc;
    acc = 16'(COEF_R) * 16'(rgb[23:16])
        + 16'(COEF_G) * 16'(rgb[15:8])
        + 16'(COEF_B) * 16'(rgb[7:0]);
    return acc[15:8];
  endfunction

  function automatic logic [BG_AW-1:0] bg_addr(input logic [8:0] row, input logic [8:0] col);
    return BG_AW'(row) * BG_AW'(BG_W) + BG_AW'(col);
  endfunction

endpackage

// File: rtl/foreground_extractor_bg_model_ram.sv
// 76800x8 simple dual-port background model: one write port, one registered read port.
// Intentionally unreset so it maps onto block RAM.
module bg_model_ram
  import foreground_extractor_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [BG_AW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic             re_i,
  input  logic [BG_AW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [BG_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/foreground_extractor.sv
// Pixel-rate background subtraction: 2x2-subsampled luma model, running-average update,
// 1-bit foreground decision three cycles after each input pixel.
//
//   state    | meaning
//   ST_LEARN | model cells copied from incoming luma, foregnd_px held at 0
//   ST_RUN   | compare against model, running-average / creep update, bg_ready=1
module foreground_extractor
  import foreground_extractor_pkg::*;
#(
  parameter int THRESH       = 24,
  parameter int ALPHA_SHIFT  = 3,
  parameter int LEARN_FRAMES = 4
) (
  input  logic        app_clk,
  input  logic        app_rst_n,
  input  logic [10:0] vid_hpos,
  input  logic [10:0] vid_vpos,
  input  logic        vid_active_pix,
  input  logic [23:0] vid_pix_in,
  input  logic        learn_req,
  input  logic        bg_freeze,
  output logic        foregnd_px,
  output logic [10:0] fg_hpos,
  output logic [10:0] fg_vpos,
  output logic        bg_ready
);

  state_e     state_q;
  logic [3:0] frame_cnt_q;
  logic       pending_q;

  logic             in_img, owner, frame_start, frame_end, learn_px;
  logic [BG_AW-1:0] rd_addr;
  logic [7:0]       y_d;

  assign in_img      = vid_active_pix && (vid_hpos < 11'(H_IMG_RES)) && (vid_vpos < 11'(V_IMG_RES));
  assign owner       = ~vid_hpos[0] & ~vid_vpos[0];
  assign frame_start = vid_active_pix && (vid_hpos == '0) && (vid_vpos == '0);
  assign frame_end   = vid_active_pix && (vid_hpos == 11'(H_IMG_RES - 1))
                                      && (vid_vpos == 11'(V_IMG_RES - 1));
  // The frame-start pixel that consumes a pending request already belongs to the new LEARN pass.
  assign learn_px    = (state_q == ST_LEARN) || (frame_start && pending_q);
  assign rd_addr     = bg_addr(vid_vpos[9:1], vid_hpos[9:1]);
  assign y_d         = luma(vid_pix_in);

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      state_q     <= ST_LEARN;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      bg_ready    <= 1'b0;
    end else begin
      if (frame_start && pending_q) begin
        state_q     <= ST_LEARN;
        frame_cnt_q <= '0;
        bg_ready    <= 1'b0;
      end else if (frame_end && state_q == ST_LEARN) begin
        if (frame_cnt_q == 4'(LEARN_FRAMES - 1)) begin
          state_q     <= ST_RUN;
          frame_cnt_q <= '0;
          bg_ready    <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + 4'd1;
        end
      end
      // A request coinciding with a frame start is kept for the following frame start.
      pending_q <= learn_req | (pending_q & ~frame_start);
    end
  end

  logic             s1_valid_q, s1_owner_q, s1_learn_q, s1_freeze_q;
  logic [7:0]       s1_y_q;
  logic [BG_AW-1:0] s1_addr_q;
  logic [10:0]      s1_hpos_q, s1_vpos_q;

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_owner_q  <= 1'b0;
      s1_learn_q  <= 1'b0;
      s1_freeze_q <= 1'b0;
      s1_y_q      <= '0;
      s1_addr_q   <= '0;
      s1_hpos_q   <= '0;
      s1_vpos_q   <= '0;
    end else begin
      s1_valid_q  <= in_img;
      s1_owner_q  <= owner;
      s1_learn_q  <= learn_px;
      s1_freeze_q <= bg_freeze;
      s1_y_q      <= y_d;
      s1_addr_q   <= rd_addr;
      s1_hpos_q   <= vid_hpos;
      s1_vpos_q   <= vid_vpos;
    end
  end

  logic             s2_fg_q, s2_we_q;
  logic [7:0]       s2_wdata_q;
  logic [BG_AW-1:0] s2_addr_q;
  logic [10:0]      s2_hpos_q, s2_vpos_q;
  logic [7:0]       bg_rd;

  bg_model_ram u_bg_model_ram (
    .clk_i   (app_clk),
    .we_i    (s2_we_q),
    .waddr_i (s2_addr_q),
    .wdata_i (s2_wdata_q),
    .re_i    (in_img),
    .raddr_i (rd_addr),
    .rdata_o (bg_rd)
  );

  logic signed [8:0] diff_d, sign_d, shift_d, delta_d;
  logic [8:0]        mag_d;
  logic              fg_d;
  logic [7:0]        wdata_d;

  // Every update steps toward Y by at most |d|, so 8-bit wrap arithmetic never overflows.
  always_comb begin
    diff_d  = $signed({1'b0, s1_y_q}) - $signed({1'b0, bg_rd});
    mag_d   = diff_d[8] ? $unsigned(-diff_d) : $unsigned(diff_d);
    fg_d    = mag_d > 9'(THRESH);
    sign_d  = diff_d[8] ? -9'sd1 : ((diff_d != 9'sd0) ? 9'sd1 : 9'sd0);
    shift_d = diff_d >>> ALPHA_SHIFT;
    delta_d = shift_d;
    if (fg_d || shift_d == 9'sd0) delta_d = sign_d;
    wdata_d = s1_learn_q ? s1_y_q : bg_rd + delta_d[7:0];
  end

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      s2_fg_q    <= 1'b0;
      s2_we_q    <= 1'b0;
      s2_wdata_q <= '0;
      s2_addr_q  <= '0;
      s2_hpos_q  <= '0;
      s2_vpos_q  <= '0;
      foregnd_px <= 1'b0;
      fg_hpos    <= '0;
      fg_vpos    <= '0;
    end else begin
      s2_fg_q    <= s1_valid_q & ~s1_learn_q & fg_d;
      s2_we_q    <= s1_valid_q & s1_owner_q & ~s1_freeze_q;
      s2_wdata_q <= wdata_d;
      s2_addr_q  <= s1_addr_q;
      s2_hpos_q  <= s1_hpos_q;
      s2_vpos_q  <= s1_vpos_q;
      foregnd_px <= s2_fg_q;
      fg_hpos    <= s2_hpos_q;
      fg_vpos    <= s2_vpos_q;
    end
  end

endmodule

// File: tb/tb_foreground_extractor.sv
// Self-checking bench for foreground_extractor: integer background model plus a
// latency-tagged scoreboard of expected {foregnd_px, fg_hpos, fg_vpos}.
module tb_foreground_extractor;

  logic        app_clk = 1'b0;
  logic        app_rst_n;
  logic [10:0] vid_hpos, vid_vpos;
  logic        vid_active_pix;
  logic [23:0] vid_pix_in;
  logic        learn_req, bg_freeze;
  logic        foregnd_px;
  logic [10:0] fg_hpos, fg_vpos;
  logic        bg_ready;

  foreground_extractor dut (
    .app_clk        (app_clk),
    .app_rst_n      (app_rst_n),
    .vid_hpos       (vid_hpos),
    .vid_vpos       (vid_vpos),
    .vid_active_pix (vid_active_pix),
    .vid_pix_in     (vid_pix_in),
    .learn_req      (learn_req),
    .bg_freeze      (bg_freeze),
    .foregnd_px     (foregnd_px),
    .fg_hpos        (fg_hpos),
    .fg_vpos        (fg_vpos),
    .bg_ready       (bg_ready)
  );

  always #5 app_clk = ~app_clk;

  int cyc = 0;
  always @(posedge app_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic        fg;
    logic [10:0] h;
    logic [10:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   bgm[int];
  bit   m_learn = 1'b1;

  always @(negedge app_clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.due != cyc) begin
        failures++;
        $display("FAIL sb_late due=%0d cyc=%0d", mon_e.due, cyc);
      end else if (foregnd_px !== mon_e.fg || fg_hpos !== mon_e.h || fg_vpos !== mon_e.v) begin
        failures++;
        $display("FAIL sb_px cyc=%0d got fg=%0b h=%0d v=%0d required fg=%0b h=%0d v=%0d",
                 cyc, foregnd_px, fg_hpos, fg_vpos, mon_e.fg, mon_e.h, mon_e.v);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Drives one pixel at a falling edge, predicts its output, updates the model, waits one cycle.
  task automatic px(input int h, input int v, input bit act, input int r, input int g,
                    input int b, input int force_fg = -1);
    int y, addr, bg, d, delta;
    bit inimg, own, e;
    inimg = act && h < 640 && v < 480;
    own   = (h % 2 == 0) && (v % 2 == 0);
    y     = (77 * r + 150 * g + 29 * b) / 256;
    addr  = (v / 2) * 320 + h / 2;
    e     = 1'b0;
    if (inimg && !m_learn) begin
      bg = bgm.exists(addr) ? bgm[addr] : 0;
      d  = y - bg;
      e  = (d > 24) || (d < -24);
    end
    if (force_fg >= 0) e = (force_fg != 0);
    vid_hpos       = 11'(h);
    vid_vpos       = 11'(v);
    vid_active_pix = act;
    vid_pix_in     = {8'(r), 8'(g), 8'(b)};
    sb.push_back('{cyc + 3, e, 11'(h), 11'(v)});
    if (inimg && own && !bg_freeze) begin
      if (m_learn) bgm[addr] = y;
      else begin
        d = y - bgm[addr];
        if (d > 24 || d < -24) delta = (d > 0) ? 1 : -1;
        else begin
          delta = (d >= 0) ? d / 8 : -((-d + 7) / 8);
          if (delta == 0 && d != 0) delta = (d > 0) ? 1 : -1;
        end
        bgm[addr] = bgm[addr] + delta;
      end
    end
    @(negedge app_clk);
  endtask

  task automatic gray(input int h, input int v, input int val, input int force_fg = -1);
    px(h, v, 1'b1, val, val, val, force_fg);
  endtask

  task automatic fstart(input int val);
    gray(0, 0, val);
  endtask

  // Sparse frame: a 12x12 window around the image centre plus off-image and idle pixels.
  task automatic fbody(input int bgv, input int pv, input bit patch);
    for (int r = 238; r < 250; r++) begin
      for (int c = 318; c < 330; c++)
        gray(c, r, (patch && r >= 240 && r < 248 && c >= 320 && c < 328) ? pv : bgv);
      for (int i = 0; i < 4; i++) px(330 + i, r, 1'b0, 0, 0, 0);
    end
    px(640, 240, 1'b1, 255, 255, 255);
    px(320, 480, 1'b1, 255, 255, 255);
    px(322, 240, 1'b0, 255, 255, 255);
    gray(638, 478, bgv);
  endtask

  task automatic fend(input int val);
    gray(639, 479, val);
  endtask

  task automatic frame(input int bgv, input int pv, input bit patch);
    fstart(bgv);
    fbody(bgv, pv, patch);
    fend(bgv);
  endtask

  // Reads a model cell through a non-owner pixel, using the threshold boundary on both sides.
  task automatic probe(input int b);
    gray(321, 241, b + 24, 0);
    gray(321, 241, b + 25, 1);
    if (b >= 25) begin
      gray(321, 241, b - 24, 0);
      gray(321, 241, b - 25, 1);
    end
  endtask

  task automatic check_ready(input string name, input logic req);
    checks++;
    if (bg_ready !== req) begin
      failures++;
      $display("FAIL %s bg_ready got=%0b required=%0b", name, bg_ready, req);
    end
  endtask

  task automatic test_reset();
    app_rst_n = 1'b0; learn_req = 1'b0; bg_freeze = 1'b0;
    vid_hpos = '0; vid_vpos = '0; vid_active_pix = 1'b0; vid_pix_in = '0;
    repeat (3) @(negedge app_clk);
    checks++;
    if ({foregnd_px, fg_hpos, fg_vpos, bg_ready} !== 24'd0) begin
      failures++;
      $display("FAIL reset_outputs got fg=%0b h=%0d v=%0d rdy=%0b required all 0",
               foregnd_px, fg_hpos, fg_vpos, bg_ready);
    end
    app_rst_n = 1'b1;
    @(negedge app_clk);
    check_ready("reset_ready", 1'b0);
  endtask

  task automatic test_learn();
    m_learn = 1'b1;
    for (int f = 0; f < 3; f++) frame(100, 0, 1'b0);
    check_ready("learn_after3", 1'b0);
    fstart(100);
    fbody(100, 0, 1'b0);
    check_ready("learn_before_end4", 1'b0);
    fend(100);
    check_ready("learn_after4", 1'b1);
    m_learn = 1'b0;
  endtask

  task automatic test_patch();
    frame(100, 200, 1'b1);
    probe(101);
    frame(100, 0, 1'b0);
    probe(100);
  endtask

  task automatic test_drift();
    frame(110, 0, 1'b0);
    probe(101);
  endtask

  task automatic test_small_d();
    frame(98, 0, 1'b0);
    probe(100);
    frame(97, 0, 1'b0);
    probe(99);
    frame(102, 0, 1'b0);
    probe(100);
  endtask

  task automatic test_luma();
    px(321, 241, 1'b1, 255, 0, 0, 0);
    px(321, 241, 1'b1, 0, 255, 0, 1);
    px(321, 241, 1'b1, 0, 0, 255, 1);
    px(321, 241, 1'b1, 255, 255, 255, 1);
    px(321, 241, 1'b1, 100, 120, 90, 0);
  endtask

  task automatic test_freeze();
    bg_freeze = 1'b1;
    for (int f = 0; f < 3; f++) frame(200, 0, 1'b0);
    bg_freeze = 1'b0;
    check_ready("freeze_ready", 1'b1);
    probe(100);
  endtask

  task automatic test_relearn();
    fstart(100);
    learn_req = 1'b1;
    gray(331, 101, 100);
    learn_req = 1'b0;
    fbody(100, 0, 1'b0);
    fend(100);
    check_ready("relearn_pending", 1'b1);
    m_learn = 1'b1;
    fstart(50);
    check_ready("relearn_drop", 1'b0);
    fbody(50, 0, 1'b0);
    fend(50);
    for (int f = 0; f < 3; f++) frame(50, 0, 1'b0);
    check_ready("relearn_done", 1'b1);
    m_learn = 1'b0;
    probe(50);
  endtask

  task automatic test_back_to_back_req();
    learn_req = 1'b1;
    fstart(50);
    learn_req = 1'b0;
    check_ready("coincident_stay_run", 1'b1);
    fbody(50, 60, 1'b1);
    fend(50);
    check_ready("coincident_frame_end", 1'b1);
    m_learn = 1'b1;
    fstart(50);
    check_ready("coincident_drop", 1'b0);
    fbody(50, 0, 1'b0);
    fend(50);
    for (int f = 0; f < 3; f++) frame(50, 0, 1'b0);
    check_ready("coincident_done", 1'b1);
    m_learn = 1'b0;
    probe(50);
  endtask

  task automatic test_async_reset();
    bg_freeze = 1'b1;
    for (int c = 320; c < 328; c++) gray(c, 240, 200);
    checks++;
    if (foregnd_px !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_fg got=%0b required=1", foregnd_px);
    end
    #2;
    app_rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({foregnd_px, fg_hpos, fg_vpos, bg_ready} !== 24'd0) begin
      failures++;
      $display("FAIL async_reset got fg=%0b h=%0d v=%0d rdy=%0b required all 0",
               foregnd_px, fg_hpos, fg_vpos, bg_ready);
    end
    @(negedge app_clk);
    app_rst_n = 1'b1;
    bg_freeze = 1'b0;
    @(negedge app_clk);
  endtask

  initial begin
    test_reset();
    test_learn();
    test_patch();
    test_drift();
    test_small_d();
    test_luma();
    test_freeze();
    test_relearn();
    test_back_to_back_req();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
